// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the bubble instruction and field types.
// Used by the IF, ID, ID_EX and hazard blocks.
package cpu_pkg;

    localparam int INSTR_W = 19;
    localparam int PC_W    = 8;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [PC_W-1:0]    pc_t;

    localparam instr_t NOP_INSTR = 19'd0;

endpackage : cpu_pkg

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline field register: async active-low reset, synchronous clear
// (which takes priority over enable), and hold when the enable is low.
module pipe_reg_en_clr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values, regardless of how many registers share this clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (i_clr) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : pipe_reg_en_clr

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures instruction and PC+1 each edge, holds on
// stall, and collapses to a NOP bubble (valid=0) on flush or reset.
module if_id_pipe_reg
    import cpu_pkg::*;
#(
    parameter int     INSTR_W_P   = INSTR_W,
    parameter int     PC_W_P      = PC_W,
    parameter instr_t NOP_INSTR_P = NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W_P-1:0] IF_instruction,
    input  logic [PC_W_P-1:0]    IF_pc_plus_one,
    input  logic                 IF_IDwrite,
    input  logic                 IF_IDflush,
    output logic [INSTR_W_P-1:0] ID_instruction,
    output logic [PC_W_P-1:0]    ID_pc_plus_one,
    output logic                 ID_valid
);

    pipe_reg_en_clr #(
        .WIDTH   (INSTR_W_P),
        .RST_VAL (NOP_INSTR_P)
    ) u_instr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (IF_IDwrite),
        .i_clr (IF_IDflush),
        .i_d   (IF_instruction),
        .o_q   (ID_instruction)
    );

    pipe_reg_en_clr #(
        .WIDTH   (PC_W_P),
        .RST_VAL ('0)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (IF_IDwrite),
        .i_clr (IF_IDflush),
        .i_d   (IF_pc_plus_one),
        .o_q   (ID_pc_plus_one)
    );

    // Valid shares the same enable/clear, so it becomes 1 on any capture and 0 on any bubble.
    pipe_reg_en_clr #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_valid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (IF_IDwrite),
        .i_clr (IF_IDflush),
        .i_d   (1'b1),
        .o_q   (ID_valid)
    );

endmodule : if_id_pipe_reg

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios then random traffic
// against a reference model of the register's capture/hold/bubble behaviour.
module tb_if_id_pipe_reg;
    import cpu_pkg::*;

    logic   clk;
    logic   rst_n;
    instr_t IF_instruction;
    pc_t    IF_pc_plus_one;
    logic   IF_IDwrite;
    logic   IF_IDflush;
    instr_t ID_instruction;
    pc_t    ID_pc_plus_one;
    logic   ID_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: what the ID stage should currently be holding.
    instr_t exp_instr;
    pc_t    exp_pc;
    logic   exp_valid;

    if_id_pipe_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_instruction (IF_instruction),
        .IF_pc_plus_one (IF_pc_plus_one),
        .IF_IDwrite     (IF_IDwrite),
        .IF_IDflush     (IF_IDflush),
        .ID_instruction (ID_instruction),
        .ID_pc_plus_one (ID_pc_plus_one),
        .ID_valid       (ID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".instr"}, 32'(ID_instruction), 32'(exp_instr));
        check({tag, ".pc"},    32'(ID_pc_plus_one), 32'(exp_pc));
        check({tag, ".valid"}, 32'(ID_valid),       32'(exp_valid));
    endtask

    task automatic model_bubble();
        exp_instr = NOP_INSTR;
        exp_pc    = '0;
        exp_valid = 1'b0;
    endtask

    // One clock: glitch inputs early in the cycle, settle them at the falling edge,
    // let the rising edge capture, then compare #1 later.
    task automatic step(input string tag, input instr_t ins, input pc_t pc,
                        input logic wr, input logic fl);
        IF_instruction = instr_t'($urandom);
        IF_pc_plus_one = pc_t'($urandom);
        IF_IDwrite     = ~wr;
        IF_IDflush     = ~fl;
        @(negedge clk);
        IF_instruction = ins;
        IF_pc_plus_one = pc;
        IF_IDwrite     = wr;
        IF_IDflush     = fl;
        @(posedge clk);
        if (fl) begin
            model_bubble();
        end else if (wr) begin
            exp_instr = ins;
            exp_pc    = pc;
            exp_valid = 1'b1;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic   wr, fl;
        instr_t ins;
        pc_t    pc;

        rst_n          = 1'b0;
        IF_instruction = 19'h7FFFF;
        IF_pc_plus_one = 8'hFF;
        IF_IDwrite     = 1'b1;
        IF_IDflush     = 1'b0;
        model_bubble();
        #2;
        check_outputs("reset_init");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("reset_release");

        step("pass0", 19'd0, 8'd0, 1'b1, 1'b0);
        step("pass1", 19'd1, 8'd1, 1'b1, 1'b0);
        step("pass2", 19'd2, 8'd2, 1'b1, 1'b0);

        step("stall3", 19'd3, 8'd3, 1'b0, 1'b0);
        step("stall4", 19'd4, 8'd4, 1'b0, 1'b0);
        step("resume5", 19'd5, 8'd5, 1'b1, 1'b0);

        step("flush6", 19'd6, 8'd6, 1'b1, 1'b1);
        step("after_flush7", 19'd7, 8'd7, 1'b1, 1'b0);
        step("flush_in_stall", 19'd8, 8'd8, 1'b0, 1'b1);
        step("stall_bubble", 19'd9, 8'd9, 1'b0, 1'b0);

        step("wrap_max", 19'h7FFFF, 8'hFF, 1'b1, 1'b0);
        step("wrap_zero_pc", 19'h12345, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while write is requesting a capture.
        IF_instruction = 19'h7FFFF;
        IF_pc_plus_one = 8'hFF;
        IF_IDwrite     = 1'b1;
        IF_IDflush     = 1'b0;
        #1;
        rst_n = 1'b0;
        model_bubble();
        #1;
        check_outputs("async_reset_immediate");
        @(posedge clk);
        #1;
        check_outputs("async_reset_over_edge");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("async_reset_release");

        // Random traffic; unused data is driven to X to prove it never leaks out.
        for (int i = 0; i < 300; i++) begin
            wr  = ($urandom_range(0, 99) < 70);
            fl  = ($urandom_range(0, 99) < 15);
            ins = instr_t'($urandom);
            pc  = pc_t'($urandom);
            if (!wr || fl) begin
                ins = 'x;
                pc  = 'x;
            end
            step("random", ins, pc, wr, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_id_pipe_reg

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
- Pipeline register between the Instruction Fetch (IF) and Instruction Decode (ID) stages of the 19-bit CPU.
- Captures the fetched 19-bit instruction and its 8-bit PC+1 value on each rising clock edge.
- Holds its contents when the hazard unit stalls (write enable low).
- Can be flushed to a NOP bubble on a taken branch or jump.

Parameters:
- INSTR_W, 19, instruction width in bits.
- PC_W, 8, program counter width in bits.
- NOP_INSTR, 19'd0, instruction value loaded on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- IF_instruction  input  INSTR_W  instruction fetched in IF.
- IF_pc_plus_one  input  PC_W  PC+1 of the fetched instruction.
- IF_IDwrite  input  1  register write enable; 0 = stall/hold.
- IF_IDflush  input  1  synchronous flush; inserts a bubble.
- ID_instruction  output  INSTR_W  registered instruction to ID.
- ID_pc_plus_one  output  PC_W  registered PC+1 to ID.
- ID_valid  output  1  1 = ID holds a real fetched instruction; 0 = bubble.

Behaviour:
- Reset: when rst_n=0, asynchronously and immediately force:
  - ID_instruction=NOP_INSTR
  - ID_pc_plus_one=0
  - ID_valid=0
- Reset is held while rst_n is low, takes effect mid-operation regardless of clock, and overrides all other inputs.
- First capture after release is on the first rising clk edge with rst_n=1.
- Each rising clk edge with rst_n=1, priority order:
  1. IF_IDflush=1: ID_instruction<=NOP_INSTR, ID_pc_plus_one<=0, ID_valid<=0. Flush wins over IF_IDwrite=0 (flush during stall still clears).
  2. Else IF_IDwrite=1: ID_instruction<=IF_instruction, ID_pc_plus_one<=IF_pc_plus_one, ID_valid<=1.
  3. Else (IF_IDwrite=0): all outputs hold their previous values.
- Latency: exactly one clock edge from IF inputs to ID outputs.
- Outputs are driven only by flops; no combinational path from any input to any output.
- Data is passed through unmodified (no arithmetic). All bits of each field are captured together; no partial update.
- Inputs that change between edges have no effect until the next edge.
- A stall of N cycles holds the last captured value for N cycles. When IF_IDwrite returns to 1, the value present at that edge is captured.
- X on IF_instruction or IF_pc_plus_one while IF_IDwrite=0 or IF_IDflush=1 must not propagate to the outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W=19, PC_W=8
  - NOP_INSTR constant
  - typedefs instr_t (logic [18:0]) and pc_t (logic [7:0])
- These are reused by the IF, ID, ID_EX and hazard blocks.
- No sub-module is required. Optionally, one generic enable/clear register, pipe_reg_en_clr (width parameter, async active-low reset, sync clear, enable), instantiated once per field.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with IF_instruction=19'h7FFFF, IF_pc_plus_one=8'hFF, write=1 -> outputs go to 0/0/valid=0 immediately, before the next edge; they stay 0 while reset is held.
- Pass-through: write=1, flush=0; drive instr 0,1,2 and pc 0,1,2 on successive cycles -> ID outputs show the same values one edge later each; ID_valid=1.
- Stall: after capturing instr=2/pc=2, set write=0 and drive instr 3 then 4 (pc 3, 4) -> outputs stay 2/2 for both cycles. Then write=1 with instr=5/pc=5 -> outputs become 5/5 at the next edge.
- Flush: with outputs holding 5/5, assert flush=1 and write=1 with instr=6 -> outputs 0/0, valid=0 after the edge. Deassert flush with instr=7 -> 7/7, valid=1.
- Flush during stall: write=0, flush=1 -> outputs clear to bubble (flush priority).
- Wrap/width: IF_pc_plus_one=8'hFF and instr=19'h7FFFF -> captured exactly with no truncation. Next pc=8'h00 -> captured as 0.
